// File: rtl/shiftreg_univ.sv
// Universal N-bit register: hold/load/shift/rotate/arithmetic-shift/preset,
// either one step per enabled cycle or as a counted multi-step sequence with busy/done.
module shiftreg_univ #(
    parameter int N  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic          start,
    input  logic [AW-1:0] amt,
    input  logic          sin,
    input  logic [N-1:0]  d,
    output logic [N-1:0]  q,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [2:0] M_HOLD   = 3'b000;
    localparam logic [2:0] M_LOAD   = 3'b001;
    localparam logic [2:0] M_SHL    = 3'b010;
    localparam logic [2:0] M_SHR    = 3'b011;
    localparam logic [2:0] M_ROL    = 3'b100;
    localparam logic [2:0] M_ROR    = 3'b101;
    localparam logic [2:0] M_ASR    = 3'b110;
    localparam logic [2:0] M_PRESET = 3'b111;

    localparam logic [AW-1:0] CNT_ZERO = '0;
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);

    state_t        state_q;
    logic [2:0]    mreg_q;
    logic [AW-1:0] cnt_q;
    logic [N-1:0]  q_q;
    logic          sout_q;
    logic          busy_q;
    logic          done_q;

    logic [2:0]    step_mode;
    logic [N-1:0]  step_q_d;
    logic          step_sout_d;
    logic [AW-1:0] cnt_d;

    // One step of the selected operation; result is {sout, q}.
    function automatic logic [N:0] step_f(input logic [2:0]   m,
                                          input logic [N-1:0] cur,
                                          input logic         so,
                                          input logic         s,
                                          input logic [N-1:0] din);
        logic [N:0] r;
        case (m)
            M_LOAD:   r = {so, din};
            M_SHL:    r = {cur[N-1], cur[N-2:0], s};
            M_SHR:    r = {cur[0], s, cur[N-1:1]};
            M_ROL:    r = {cur[N-1], cur[N-2:0], cur[N-1]};
            M_ROR:    r = {cur[0], cur[0], cur[N-1:1]};
            M_ASR:    r = {cur[0], cur[N-1], cur[N-1:1]};
            M_PRESET: r = {so, {N{1'b1}}};
            default:  r = {so, cur};
        endcase
        return r;
    endfunction

    always_comb begin
        step_mode = (state_q == RUN) ? mreg_q : mode;
        {step_sout_d, step_q_d} = step_f(step_mode, q_q, sout_q, sin, d);
        // Non-shifting modes run exactly one step regardless of amt.
        if (mode == M_HOLD || mode == M_LOAD || mode == M_PRESET)
            cnt_d = CNT_ONE;
        else
            cnt_d = amt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mreg_q  <= M_HOLD;
            cnt_q   <= CNT_ZERO;
            q_q     <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (!en) begin
            done_q <= 1'b0;
        end else if (state_q == IDLE) begin
            done_q <= 1'b0;
            if (start) begin
                mreg_q  <= mode;
                cnt_q   <= cnt_d;
                state_q <= RUN;
                busy_q  <= 1'b1;
            end else begin
                q_q    <= step_q_d;
                sout_q <= step_sout_d;
            end
        end else begin
            if (cnt_q != CNT_ZERO) begin
                q_q    <= step_q_d;
                sout_q <= step_sout_d;
                cnt_q  <= cnt_q - CNT_ONE;
                done_q <= 1'b0;
            end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shiftreg_univ.sv
// Directed bench for shiftreg_univ: single-step modes, sequences, stalls and handshake corners.
module tb_shiftreg_univ;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       start = 1'b0;
    logic [3:0] amt = 4'd0;
    logic       sin = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    shiftreg_univ #(.N(8), .AW(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start), .amt(amt),
        .sin(sin), .d(d), .q(q), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_q(input logic [7:0] val);
        en = 1'b1; start = 1'b0; mode = 3'b001; d = val;
        tick();
        mode = 3'b000;
        n_tests++;
        if (q !== val) begin $display("FAIL load_q q=%h exp=%h", q, val); n_fail++; end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({q, sout, busy, done} !== 11'd0) begin
            $display("FAIL reset_init q=%h sout=%b busy=%b done=%b exp all 0", q, sout, busy, done); n_fail++;
        end
        @(negedge clk) rst = 1'b0;
        load_q(8'hA5);
        mode = 3'b010; amt = 4'd5; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        n_tests++;
        if (busy !== 1'b1 || q !== 8'hA5) begin
            $display("FAIL reset_pre busy=%b q=%h exp busy=1 q=a5", busy, q); n_fail++;
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({q, sout, busy, done} !== 11'd0) begin
            $display("FAIL reset_mid q=%h sout=%b busy=%b done=%b exp all 0", q, sout, busy, done); n_fail++;
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL reset_after cyc=%0d done=%b busy=%b exp 0 0", i, done, busy); n_fail++;
            end
        end
    endtask

    task automatic test_single_step();
        load_q(8'b1001_0110);
        mode = 3'b010; sin = 1'b1;
        tick();
        n_tests++;
        if (q !== 8'b0010_1101 || sout !== 1'b1) begin
            $display("FAIL shl q=%b sout=%b exp 00101101 1", q, sout); n_fail++;
        end
        mode = 3'b110; sin = 1'b0;
        tick();
        n_tests++;
        if (q !== 8'b0001_0110 || sout !== 1'b1) begin
            $display("FAIL asr q=%b sout=%b exp 00010110 1", q, sout); n_fail++;
        end
        mode = 3'b011; sin = 1'b1;
        tick();
        n_tests++;
        if (q !== 8'b1000_1011 || sout !== 1'b0) begin
            $display("FAIL shr q=%b sout=%b exp 10001011 0", q, sout); n_fail++;
        end
        mode = 3'b101;
        tick();
        n_tests++;
        if (q !== 8'b1100_0101 || sout !== 1'b1) begin
            $display("FAIL ror q=%b sout=%b exp 11000101 1", q, sout); n_fail++;
        end
        mode = 3'b111;
        tick();
        n_tests++;
        if (q !== 8'hFF || sout !== 1'b1) begin
            $display("FAIL preset q=%h sout=%b exp ff 1", q, sout); n_fail++;
        end
        mode = 3'b000; sin = 1'b0;
    endtask

    task automatic test_sequence();
        logic [7:0] exp_q [3] = '{8'h03, 8'h06, 8'h0C};
        int busy_cnt;
        load_q(8'h81);
        mode = 3'b100; amt = 4'd3; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        busy_cnt = busy ? 1 : 0;
        n_tests++;
        if (q !== 8'h81 || busy !== 1'b1) begin
            $display("FAIL seq_e0 q=%h busy=%b exp 81 1", q, busy); n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy) busy_cnt++;
            n_tests++;
            if (q !== exp_q[i] || done !== 1'b0) begin
                $display("FAIL seq_step%0d q=%h done=%b exp %h 0", i + 1, q, done, exp_q[i]); n_fail++;
            end
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h0C || busy_cnt != 4) begin
            $display("FAIL seq_done done=%b busy=%b q=%h busy_cycles=%0d exp 1 0 0c 4", done, busy, q, busy_cnt); n_fail++;
        end
        tick();
        n_tests++;
        if (done !== 1'b0) begin $display("FAIL seq_pulse done=%b exp 0", done); n_fail++; end
    endtask

    task automatic test_stall();
        load_q(8'hF0);
        mode = 3'b011; amt = 4'd4; sin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        tick();
        tick();
        n_tests++;
        if (q !== 8'h3C) begin $display("FAIL stall_pre q=%h exp 3c", q); n_fail++; end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (q !== 8'h3C || busy !== 1'b1 || done !== 1'b0) begin
                $display("FAIL stall_hold%0d q=%h busy=%b done=%b exp 3c 1 0", i, q, busy, done); n_fail++;
            end
        end
        en = 1'b1;
        tick();
        tick();
        n_tests++;
        if (q !== 8'h0F || done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL stall_last q=%h done=%b busy=%b exp 0f 0 1", q, done, busy); n_fail++;
        end
        tick();
        n_tests++;
        if (q !== 8'h0F || done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL stall_done q=%h done=%b busy=%b exp 0f 1 0", q, done, busy); n_fail++;
        end
        en = 1'b0;
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL en_low_done done=%b busy=%b exp 0 0", done, busy); n_fail++;
        end
        en = 1'b1;
    endtask

    task automatic test_amt0_load();
        mode = 3'b010; amt = 4'd0; sin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        n_tests++;
        if (busy !== 1'b1 || q !== 8'h0F) begin
            $display("FAIL amt0_e0 busy=%b q=%h exp 1 0f", busy, q); n_fail++;
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h0F) begin
            $display("FAIL amt0_done done=%b busy=%b q=%h exp 1 0 0f", done, busy, q); n_fail++;
        end
        sin = 1'b0;
        mode = 3'b001; amt = 4'd7; d = 8'h5A; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        n_tests++;
        if (q !== 8'h0F || busy !== 1'b1) begin
            $display("FAIL ldseq_e0 q=%h busy=%b exp 0f 1", q, busy); n_fail++;
        end
        tick();
        d = 8'h33;
        n_tests++;
        if (q !== 8'h5A || done !== 1'b0) begin
            $display("FAIL ldseq_e1 q=%h done=%b exp 5a 0", q, done); n_fail++;
        end
        tick();
        n_tests++;
        if (q !== 8'h5A || done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL ldseq_done q=%h done=%b busy=%b exp 5a 1 0", q, done, busy); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        load_q(8'h81);
        mode = 3'b101; amt = 4'd2; start = 1'b1;
        tick();
        mode = 3'b111;
        tick();
        n_tests++;
        if (q !== 8'hC0 || sout !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL ign_s1 q=%h sout=%b busy=%b exp c0 1 1", q, sout, busy); n_fail++;
        end
        tick();
        n_tests++;
        if (q !== 8'h60 || sout !== 1'b0) begin
            $display("FAIL ign_s2 q=%h sout=%b exp 60 0", q, sout); n_fail++;
        end
        tick();
        n_tests++;
        if (q !== 8'h60 || done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL ign_done q=%h done=%b busy=%b exp 60 1 0", q, done, busy); n_fail++;
        end
        tick();
        start = 1'b0; mode = 3'b000;
        n_tests++;
        if (q !== 8'h60 || busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL b2b_accept q=%h busy=%b done=%b exp 60 1 0", q, busy, done); n_fail++;
        end
        tick();
        n_tests++;
        if (q !== 8'hFF || busy !== 1'b1) begin
            $display("FAIL b2b_preset q=%h busy=%b exp ff 1", q, busy); n_fail++;
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'hFF) begin
            $display("FAIL b2b_done done=%b busy=%b q=%h exp 1 0 ff", done, busy, q); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_sequence();
        test_stall();
        test_amt0_load();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
